// File: rtl/seq_pattern_det.sv
// Programmable serial bit-pattern detector with runtime-loadable pattern/length, overlap control and saturating match counter.
// Optional macro PATTERN_MASK_EN adds a cfg_mask port that marks don't-care bit positions in the compare.
module seq_pattern_det #(
  parameter int                 PAT_W       = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 16,
  parameter logic [PAT_W-1:0]   DEF_PATTERN = PAT_W'(8'b0011_0101),
  parameter logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(6),
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [PAT_W-1:0]   cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
`ifdef PATTERN_MASK_EN
  input  logic [PAT_W-1:0]   cfg_mask,
`endif
  input  logic               cfg_overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  typedef enum logic {FILL, ARMED} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  state_t            state;
  logic [PAT_W-1:0]  pattern_q;
  logic [LEN_W-1:0]  len_q;
  logic              overlap_q;
  logic [PAT_W-1:0]  mask_q;
  logic [LEN_W-1:0]  fill;

  // The oldest bit of a PAT_W-deep history never reaches the compare window, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0]  history;

  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  len_mask;
  logic [LEN_W:0]    fill_inc;
  logic [LEN_W-1:0]  fill_next;
  logic              reached;
  logic              hit;
  logic              do_match;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)
      return LEN_W'(1);
    else if (l > MAX_LEN)
      return MAX_LEN;
    else
      return l;
  endfunction

  always_comb begin
    window   = {history, in_bit};
    fill_inc = {1'b0, fill} + 1'b1;
    reached  = (fill_inc >= {1'b0, len_q});
    if (fill_inc > {1'b0, MAX_LEN})
      fill_next = MAX_LEN;
    else
      fill_next = fill_inc[LEN_W-1:0];
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++)
      len_mask[i] = ((LEN_W+1)'(i) < {1'b0, len_q});
    hit      = (((window ^ pattern_q) & len_mask & mask_q) == '0);
    do_match = in_valid && !cfg_load && reached && hit;
  end

`ifdef PATTERN_MASK_EN
  always_ff @(posedge clk) begin
    if (rst)
      mask_q <= '1;
    else if (cfg_load)
      mask_q <= cfg_mask;
  end
`else
  assign mask_q = '1;
`endif

  assign armed = (state == ARMED);

  // A non-overlapping match restarts the fill, so the next occurrence must be built from fresh bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= clamp_len(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      history   <= '0;
      fill      <= '0;
      state     <= FILL;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= 1'b0;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        len_q     <= clamp_len(cfg_len);
        overlap_q <= cfg_overlap;
        history   <= '0;
        fill      <= '0;
        state     <= FILL;
      end else if (in_valid) begin
        if (do_match) begin
          match <= 1'b1;
          if (match_cnt != '1)
            match_cnt <= match_cnt + 1'b1;
        end
        if (do_match && !overlap_q) begin
          history <= '0;
          fill    <= '0;
          state   <= FILL;
        end else begin
          history <= window[PAT_W-2:0];
          fill    <= fill_next;
          state   <= reached ? ARMED : FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_det.sv
// Scoreboard bench for seq_pattern_det: a bit-queue reference model predicts each cycle, a monitor compares.
// A second instance with a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_seq_pattern_det;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        cfg_load = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic        match, armed, match_s, armed_s;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt_s;

  always #5 clk = ~clk;

  seq_pattern_det #(.PAT_W(8), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match), .match_cnt(match_cnt), .armed(armed)
  );

  seq_pattern_det #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match_s), .match_cnt(match_cnt_s), .armed(armed_s)
  );

  typedef struct {
    logic        match;
    logic        armed;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Reference model: the accepted bits since the last clear, newest at the back.
  bit          m_hist[$];
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ovl;
  int          m_cnt;
  int          m_cnt_s;
  bit          m_armed;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit b, input bit l,
                               input logic [7:0] p, input logic [3:0] ln, input bit o);
    exp_t e;
    bit   hit;
    @(negedge clk);
    rst = r; in_valid = v; in_bit = b; cfg_load = l;
    cfg_pattern = p; cfg_len = ln; cfg_overlap = o;
    e.match = 1'b0;
    if (r) begin
      m_pat = 8'b0011_0101; m_len = 6; m_ovl = 1'b1;
      m_hist.delete(); m_cnt = 0; m_cnt_s = 0; m_armed = 1'b0;
    end else if (l) begin
      m_pat = p;
      m_len = (ln == 0) ? 1 : ((ln > 8) ? 8 : int'(ln));
      m_ovl = o;
      m_hist.delete();
      m_armed = 1'b0;
    end else if (v) begin
      m_hist.push_back(b);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      hit = (m_hist.size() >= m_len);
      if (hit)
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size()-1-k] != m_pat[k]) hit = 1'b0;
      e.match = hit;
      if (hit) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
      end
      if (hit && !m_ovl) begin
        m_hist.delete();
        m_armed = 1'b0;
      end else begin
        m_armed = (m_hist.size() >= m_len);
      end
    end
    e.armed = m_armed;
    e.cnt   = 16'(m_cnt);
    e.cnt_s = 2'(m_cnt_s);
    exp_q.push_back(e);
  endtask

  task automatic sendBit(input bit b);
    applyStimulus(1'b0, 1'b1, b, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'($urandom), 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'hFF, 4'h2, 1'b0);
  endtask

  task automatic loadCfg(input logic [7:0] p, input logic [3:0] ln, input bit o);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, p, ln, o);
  endtask

  task automatic sendStream(input logic [31:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      sendBit(bits[i]);
      if (gaps) idle();
    end
  endtask

  // Monitor: every cycle the DUT presents match/armed/count; compare against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("match",       16'(match),       16'(mon_e.match));
        checkOutput("armed",       16'(armed),       16'(mon_e.armed));
        checkOutput("match_cnt",   match_cnt,        mon_e.cnt);
        checkOutput("match_sat",   16'(match_s),     16'(mon_e.match));
        checkOutput("match_cnt_s", 16'(match_cnt_s), 16'(mon_e.cnt_s));
      end
    end
  end

  initial begin
    doReset();
    doReset();

    sendStream(32'b110101, 6, 1'b0);
    idle(); idle();

    loadCfg(8'b101, 4'd3, 1'b1);
    sendStream(32'b10101, 5, 1'b0);
    loadCfg(8'b101, 4'd3, 1'b0);
    sendStream(32'b10101, 5, 1'b0);

    doReset();
    sendStream(32'b110101, 6, 1'b1);

    doReset();
    sendStream(32'b1101, 4, 1'b0);
    doReset();
    sendStream(32'b01, 2, 1'b0);
    sendStream(32'b110101, 6, 1'b0);

    loadCfg(8'h01, 4'd1, 1'b1);
    sendStream(32'b11111, 5, 1'b0);

    loadCfg(8'h01, 4'd0, 1'b0);
    sendStream(32'b1011, 4, 1'b0);
    loadCfg(8'hA5, 4'd15, 1'b1);
    sendStream(32'b1010_0101_0100_101, 15, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 4'd2, 1'b1);
    sendStream(32'b111, 3, 1'b0);

    loadCfg(8'b11, 4'd2, 1'b1);
    sendStream(32'b111, 3, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0)
        doReset();
      else if ($urandom_range(0, 39) == 0)
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'b1, 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)),
                      1'($urandom));
      else
        applyStimulus(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
                      8'($urandom), 4'($urandom), 1'($urandom));
    end

    idle();
    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_pattern_det.md
Name: seq_pattern_det

Overview:
- Programmable serial bit-pattern detector; successor to the fixed 6-bit FSM detector.
- Runtime-loadable pattern and length, overlap or non-overlap matching, input qualifier, and a saturating match counter.
- Sits on a serial bit stream (framing or sync-word search) and flags each occurrence with a one-cycle pulse.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of length field; must hold PAT_W.
- CNT_W, 16, width of match counter.
- DEF_PATTERN, 8'b0011_0101, pattern loaded at reset, LSB-aligned.
- DEF_LEN, 6, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies in_bit; the bit is consumed only when high.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe; captures the cfg_* inputs.
- cfg_pattern  in  PAT_W  pattern, LSB-aligned; bit [len-1] is the oldest, bit [0] the newest.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = history cleared after a match.
- match  out  1  one-cycle pulse per detected occurrence.
- match_cnt  out  CNT_W  saturating occurrence count.
- armed  out  1  high when the history holds at least len valid bits.

Behaviour:
- Reset (rst=1 at clk edge):
  - shadow pattern/len/overlap <= DEF_*.
  - history <= 0, fill <= 0, state <= FILL.
  - match <= 0, match_cnt <= 0, armed <= 0.
- Config capture on cfg_load:
  - Shadow registers load cfg_* on the next edge; history and fill clear; state -> FILL.
  - match_cnt is not cleared.
  - cfg_len == 0 is treated as 1; cfg_len > PAT_W is clamped to PAT_W.
  - in_valid in the same cycle as cfg_load: the bit is discarded, and no match is possible that cycle.
- History: a PAT_W-bit shift register; on in_valid, history <= {history[PAT_W-2:0], in_bit}. fill increments and saturates at PAT_W.
- Compare: window = the low len bits of {history[PAT_W-2:0], in_bit} versus the low len bits of the shadow pattern. Combinational on the incoming bit.
- State machine (2 states):
  - FILL: fill+1 < len after the current valid bit; no match. Moves to ARMED when the accepted bit makes fill+1 >= len.
  - ARMED: every valid bit is compared.
  - On match with overlap=1: stay ARMED, history kept.
  - On match with overlap=0: history and fill clear, go to FILL.
  - cfg_load or rst from either state -> FILL.
- armed = (state == ARMED), registered.
- Latency: match is registered and goes high on the edge that consumes the completing bit; high for exactly one cycle. No match pulse when in_valid=0.
- match_cnt increments on the same edge match rises. It saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous events, priority: rst > cfg_load > in_valid.
- Reset mid-pattern: partial history is lost, with no spurious match afterwards.
- Back-to-back valid bits with matches are supported at full rate in overlap mode (e.g. pattern 11, stream 111 -> 2 pulses on consecutive cycles).

Optional Feature:
- Macro PATTERN_MASK_EN.
- Defined:
  - adds input cfg_mask [PAT_W-1:0], captured on cfg_load alongside cfg_pattern; its reset value is all ones.
  - Bit positions with mask=0 are don't-care in the compare.
- Undefined:
  - no cfg_mask port; all len bits are compared exactly.
  - Port list and behaviour otherwise identical.

Test Plan:
- Defaults after reset (110101, len 6, overlap), stream 1,1,0,1,0,1 all valid -> match high exactly on edge 6; match_cnt=1; armed high from edge 6.
- cfg_load pattern 101, len 3, overlap=1, stream 10101 -> match on bits 3 and 5, match_cnt=2. Reload with overlap=0, same stream -> match on bit 3 only, count +1.
- Default pattern, stream 110101 with in_valid low on alternate cycles -> exactly one match, on the cycle of the 6th valid bit; no pulse during gaps.
- rst asserted after 4 bits of 110101, then 01 sent -> no match. A fresh 110101 -> match; match_cnt=1.
- CNT_W=2, pattern 1, len 1, stream of 5 ones -> 5 match pulses; match_cnt stays 3 after the 3rd.
- cfg_len=0 and cfg_len=15 with PAT_W=8 -> behave as len 1 and len 8. cfg_load with in_valid=1 -> that bit ignored (fill=0 next cycle).
